// File: rtl/router_fifo_buf.sv
// ---------------------------------------------------------------------------
// router_fifo_buf
//   Per-destination output buffer of the 1x3 router. Stores header, payload
//   and parity bytes together with a header marker bit taken from lfd_state,
//   tracks the remaining packet length on the read side and presents read
//   bytes through registered outputs.
//
// Ports:
//   clock       rising-edge clock
//   reset       synchronous, active-high reset (highest priority)
//   soft_reset  synchronous flush from the controller (timeout)
//   write_enb   write request for data_in
//   read_enb    read request from the destination reader
//   lfd_state   high when data_in is a header byte (stored as marker bit)
//   data_in     byte from the register stage
//   full        combinational, occupancy == DEPTH
//   empty       combinational, occupancy == 0
//   data_out    registered read data (0 in cycles without an accepted read)
//   pkt_end     registered one-cycle pulse when the parity byte is read
// ---------------------------------------------------------------------------
module router_fifo_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16   // must equal 2**ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  soft_reset,
  input  logic                  write_enb,
  input  logic                  read_enb,
  input  logic                  lfd_state,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  pkt_end
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int LEN_W = 7;

  logic [DATA_WIDTH:0]   mem_q [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
  logic [LEN_W-1:0]      len_cnt_q,  len_cnt_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  pkt_end_q,  pkt_end_d;

  logic                  flush_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  full_s;
  logic                  empty_s;
  logic [DATA_WIDTH:0]   rd_word_s;

  assign flush_s   = reset | soft_reset;
  assign empty_s   = (wr_ptr_q == rd_ptr_q);
  assign full_s    = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                     (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  // Acceptance uses full/empty from the start of the cycle, so a read never
  // sees a word written in the same cycle and a write never lands when full.
  assign wr_acc_s  = write_enb & ~full_s;
  assign rd_acc_s  = read_enb  & ~empty_s;
  assign rd_word_s = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

  assign full     = full_s;
  assign empty    = empty_s;
  assign data_out = data_out_q;
  assign pkt_end  = pkt_end_q;

  // Next-state computation for pointers, length counter and read outputs.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    len_cnt_d  = len_cnt_q;
    data_out_d = {DATA_WIDTH{1'b0}};
    pkt_end_d  = 1'b0;
    if (flush_s) begin
      wr_ptr_d  = {PTR_W{1'b0}};
      rd_ptr_d  = {PTR_W{1'b0}};
      len_cnt_d = {LEN_W{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d   = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        data_out_d = rd_word_s[DATA_WIDTH-1:0];
        if (rd_word_s[DATA_WIDTH]) begin
          // Header: bits [7:2] hold payload length; +1 covers the parity byte.
          // A header arriving mid-packet simply reloads (truncated packet).
          len_cnt_d = {1'b0, rd_word_s[7:2]} + 7'd1;
        end else if (len_cnt_q != {LEN_W{1'b0}}) begin
          len_cnt_d = len_cnt_q - 7'd1;
          pkt_end_d = (len_cnt_q == 7'd1);
        end else begin
          len_cnt_d = len_cnt_q;
        end
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // State and output registers with synchronous reset/flush.
  always_ff @(posedge clock) begin
    if (flush_s) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      len_cnt_q  <= {LEN_W{1'b0}};
      data_out_q <= {DATA_WIDTH{1'b0}};
      pkt_end_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      len_cnt_q  <= len_cnt_d;
      data_out_q <= data_out_d;
      pkt_end_q  <= pkt_end_d;
    end
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clock) begin
    if (!flush_s && wr_acc_s) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {lfd_state, data_in};
    end
  end

endmodule
